// File: rtl/ob_msg_decoder.sv
// ob_msg_decoder
// Turns a byte-wide framed market-data stream into order book commands.
// Each message starts with a type byte: 'A' (0x41) add, 'X' (0x58) cancel,
// 'E' (0x45) execute. Multi-byte fields are big-endian. A good message
// produces exactly one command on the matching add/cancel/exec interface.
// A malformed message is dropped and counted instead.
//
// Handshakes: a transfer happens on a rising clk edge when valid and ready
// are both high. The producer holds valid and payload stable until that edge.
// A ready seen without its valid does nothing.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last  input byte stream (s_last marks end of message)
//   add_*                        add command (order id, side, price, quantity)
//   cancel_*                     cancel command (order id)
//   exec_*                       execute command (order id, executed quantity)
//   msg_count                    good messages issued (16-bit, wraps)
//   err_count                    dropped messages (16-bit, wraps)
//   dbg_state                    current FSM state (0 IDLE, 1 COLLECT, 2 ISSUE, 3 DROP)
module ob_msg_decoder #(
    parameter int PRICE_WIDTH    = 32,
    parameter int QTY_WIDTH      = 32,
    parameter int ORDER_ID_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [7:0]                s_data,
    input  logic                      s_last,
    output logic                      add_valid,
    input  logic                      add_ready,
    output logic [ORDER_ID_WIDTH-1:0] add_order_id,
    output logic                      add_side,
    output logic [PRICE_WIDTH-1:0]    add_price,
    output logic [QTY_WIDTH-1:0]      add_quantity,
    output logic                      cancel_valid,
    input  logic                      cancel_ready,
    output logic [ORDER_ID_WIDTH-1:0] cancel_order_id,
    output logic                      exec_valid,
    input  logic                      exec_ready,
    output logic [ORDER_ID_WIDTH-1:0] exec_order_id,
    output logic [QTY_WIDTH-1:0]      exec_quantity,
    output logic [15:0]               msg_count,
    output logic [15:0]               err_count,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2,
        DROP    = 2'd3
    } state_t;

    localparam logic [1:0] K_ADD    = 2'd0;
    localparam logic [1:0] K_CANCEL = 2'd1;
    localparam logic [1:0] K_EXEC   = 2'd2;

    state_t                    state_q, state_d;
    logic [1:0]                kind_q, kind_d;
    logic [4:0]                cnt_q, cnt_d;
    logic [ORDER_ID_WIDTH-1:0] id_q, id_d;
    logic                      side_q, side_d;
    logic [PRICE_WIDTH-1:0]    price_q, price_d;
    logic [QTY_WIDTH-1:0]      qty_q, qty_d;
    logic                      bad_q, bad_d;
    logic [15:0]               msg_q, msg_d;
    logic [15:0]               err_q, err_d;
    logic                      rdy_en_q;

    logic       fire;
    logic       cmd_hs;
    logic [4:0] final_idx;

    // Input is blocked while a command is outstanding, and while in reset.
    assign s_ready = rdy_en_q && (state_q != ISSUE);
    assign fire    = s_valid && s_ready;

    // Index of the last byte of the message being collected (type byte = 0).
    always_comb begin
        final_idx = 5'd8;
        case (kind_q)
            K_ADD:   final_idx = 5'd17;
            K_EXEC:  final_idx = 5'd12;
            default: final_idx = 5'd8;
        endcase
    end

    // Only the ready belonging to the pending command counts.
    always_comb begin
        cmd_hs = 1'b0;
        case (kind_q)
            K_ADD:    cmd_hs = add_ready;
            K_CANCEL: cmd_hs = cancel_ready;
            default:  cmd_hs = exec_ready;
        endcase
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        side_d  = side_q;
        price_d = price_q;
        qty_d   = qty_q;
        bad_d   = bad_q;
        msg_d   = msg_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (fire) begin
                    cnt_d = 5'd1;
                    bad_d = 1'b0;
                    if (s_data == 8'h41 || s_data == 8'h58 || s_data == 8'h45) begin
                        kind_d = (s_data == 8'h41) ? K_ADD :
                                 (s_data == 8'h58) ? K_CANCEL : K_EXEC;
                        if (s_last) begin
                            err_d = err_q + 16'd1;
                        end else begin
                            state_d = COLLECT;
                        end
                    end else begin
                        err_d = err_q + 16'd1;
                        if (!s_last) begin
                            state_d = DROP;
                        end
                    end
                end
            end

            COLLECT: begin
                if (fire) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q >= 5'd1 && cnt_q <= 5'd8) begin
                        id_d = {id_q[ORDER_ID_WIDTH-9:0], s_data};
                    end
                    if (kind_q == K_ADD) begin
                        if (cnt_q == 5'd9) begin
                            side_d = s_data[0];
                            // A side byte other than 0/1 poisons the message,
                            // but it is still collected to its end.
                            if (s_data > 8'h01) begin
                                bad_d = 1'b1;
                            end
                        end
                        if (cnt_q >= 5'd10 && cnt_q <= 5'd13) begin
                            price_d = {price_q[PRICE_WIDTH-9:0], s_data};
                        end
                        if (cnt_q >= 5'd14 && cnt_q <= 5'd17) begin
                            qty_d = {qty_q[QTY_WIDTH-9:0], s_data};
                        end
                    end
                    if (kind_q == K_EXEC && cnt_q >= 5'd9 && cnt_q <= 5'd12) begin
                        qty_d = {qty_q[QTY_WIDTH-9:0], s_data};
                    end

                    if (cnt_q == final_idx) begin
                        if (!s_last) begin
                            err_d   = err_q + 16'd1;
                            state_d = DROP;
                        end else if (bad_q) begin
                            err_d   = err_q + 16'd1;
                            state_d = IDLE;
                        end else begin
                            state_d = ISSUE;
                        end
                    end else if (s_last) begin
                        err_d   = err_q + 16'd1;
                        state_d = IDLE;
                    end
                end
            end

            ISSUE: begin
                if (cmd_hs) begin
                    msg_d   = msg_q + 16'd1;
                    state_d = IDLE;
                end
            end

            DROP: begin
                if (fire && s_last) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            kind_q   <= K_ADD;
            cnt_q    <= 5'd0;
            id_q     <= '0;
            side_q   <= 1'b0;
            price_q  <= '0;
            qty_q    <= '0;
            bad_q    <= 1'b0;
            msg_q    <= 16'd0;
            err_q    <= 16'd0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            side_q   <= side_d;
            price_q  <= price_d;
            qty_q    <= qty_d;
            bad_q    <= bad_d;
            msg_q    <= msg_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Valids decode straight from the state register so they fall with reset.
    assign add_valid       = (state_q == ISSUE) && (kind_q == K_ADD);
    assign cancel_valid    = (state_q == ISSUE) && (kind_q == K_CANCEL);
    assign exec_valid      = (state_q == ISSUE) && (kind_q == K_EXEC);
    assign add_order_id    = id_q;
    assign add_side        = side_q;
    assign add_price       = price_q;
    assign add_quantity    = qty_q;
    assign cancel_order_id = id_q;
    assign exec_order_id   = id_q;
    assign exec_quantity   = qty_q;
    assign msg_count       = msg_q;
    assign err_count       = err_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_ob_msg_decoder.sv
module tb_ob_msg_decoder;
  localparam int W = 2 + 64 + 1 + 32 + 32;

  typedef logic [7:0] bq_t[$];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_data;
  logic        add_valid, add_ready, add_side;
  logic [63:0] add_order_id;
  logic [31:0] add_price, add_quantity;
  logic        cancel_valid, cancel_ready;
  logic [63:0] cancel_order_id;
  logic        exec_valid, exec_ready;
  logic [63:0] exec_order_id;
  logic [31:0] exec_quantity;
  logic [15:0] msg_count, err_count;
  logic [1:0]  dbg_state;

  ob_msg_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .add_valid(add_valid), .add_ready(add_ready), .add_order_id(add_order_id),
    .add_side(add_side), .add_price(add_price), .add_quantity(add_quantity),
    .cancel_valid(cancel_valid), .cancel_ready(cancel_ready), .cancel_order_id(cancel_order_id),
    .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_order_id(exec_order_id),
    .exec_quantity(exec_quantity),
    .msg_count(msg_count), .err_count(err_count), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0] exp_msg = 16'd0;
  logic [15:0] exp_err = 16'd0;
  int ready_mode = 0;  // 0 random, 1 all low, 2 all high

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [1:0] k, input logic [63:0] id,
                                        input logic side, input logic [31:0] p,
                                        input logic [31:0] q);
    return {k, id, side, p, q};
  endfunction

  // Reference model: decide from the whole message what the order book should see.
  function automatic void model(input bq_t m, output bit good, output logic [W-1:0] cmd);
    int len;
    logic [63:0] id;
    logic [31:0] price, qty;
    len = 0;
    case (m[0])
      8'h41: len = 18;
      8'h58: len = 9;
      8'h45: len = 13;
      default: len = 0;
    endcase
    good = (len != 0) && (m.size() == len);
    if (good && m[0] == 8'h41 && m[9] > 8'd1) good = 0;
    cmd = '0;
    if (!good) return;
    id = 0;
    for (int i = 1; i <= 8; i++) id = id * 256 + 64'(m[i]);
    price = 0;
    qty = 0;
    if (m[0] == 8'h41) begin
      for (int i = 10; i <= 13; i++) price = price * 256 + 32'(m[i]);
      for (int i = 14; i <= 17; i++) qty = qty * 256 + 32'(m[i]);
      cmd = pack(2'd1, id, m[9][0], price, qty);
    end else if (m[0] == 8'h58) begin
      cmd = pack(2'd2, id, 1'b0, 32'd0, 32'd0);
    end else begin
      for (int i = 9; i <= 12; i++) qty = qty * 256 + 32'(m[i]);
      cmd = pack(2'd3, id, 1'b0, 32'd0, qty);
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Called and returning at posedge+1.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int t;
    logic acc;
    if ($urandom_range(0, 3) == 0) begin
      s_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data = b;
    s_last = last;
    t = 0;
    forever begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 500) begin
        n_checks++;
        n_fail++;
        $display("FAIL byte_timeout: s_ready stayed 0, required 1");
        break;
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_msg(input bq_t m);
    bit good;
    logic [W-1:0] cmd;
    model(m, good, cmd);
    if (good) begin
      exp_q.push_back(cmd);
      exp_msg = exp_msg + 16'd1;
    end else begin
      exp_err = exp_err + 16'd1;
    end
    for (int i = 0; i < m.size(); i++) send_byte(m[i], i == m.size() - 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || dbg_state != 2'd0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 400) begin
      n_fail++;
      $display("FAIL drain_timeout: pending %0d commands, state %0d, required 0", exp_q.size(), dbg_state);
      exp_q.delete();
    end
    check("msg_count", msg_count, exp_msg);
    check("err_count", err_count, exp_err);
    @(posedge clk);
    #1;
  endtask

  function automatic bq_t mk_add(input logic [63:0] id, input logic [7:0] side,
                                 input logic [31:0] p, input logic [31:0] q);
    bq_t m;
    m = {};
    m.push_back(8'h41);
    for (int i = 7; i >= 0; i--) m.push_back(id[i*8 +: 8]);
    m.push_back(side);
    for (int i = 3; i >= 0; i--) m.push_back(p[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) m.push_back(q[i*8 +: 8]);
    return m;
  endfunction

  function automatic bq_t mk_cancel(input logic [63:0] id);
    bq_t m;
    m = {};
    m.push_back(8'h58);
    for (int i = 7; i >= 0; i--) m.push_back(id[i*8 +: 8]);
    return m;
  endfunction

  function automatic bq_t mk_exec(input logic [63:0] id, input logic [31:0] q);
    bq_t m;
    m = {};
    m.push_back(8'h45);
    for (int i = 7; i >= 0; i--) m.push_back(id[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) m.push_back(q[i*8 +: 8]);
    return m;
  endfunction

  function automatic bq_t mk_random();
    bq_t m;
    int k, len, r;
    logic [7:0] t;
    m = {};
    k = $urandom_range(0, 3);
    if (k == 0) m = mk_add({$urandom, $urandom}, 8'($urandom_range(0, 1)), $urandom, $urandom);
    else if (k == 1) m = mk_cancel({$urandom, $urandom});
    else if (k == 2) m = mk_exec({$urandom, $urandom}, $urandom);
    else begin
      do t = 8'($urandom_range(0, 255)); while (t == 8'h41 || t == 8'h58 || t == 8'h45);
      m.push_back(t);
      len = $urandom_range(1, 6);
      for (int i = 1; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
      return m;
    end
    r = $urandom_range(0, 9);
    if (r == 0) begin
      len = $urandom_range(1, m.size() - 1);
      while (m.size() > len) void'(m.pop_back());
    end else if (r == 1) begin
      repeat ($urandom_range(1, 3)) m.push_back(8'($urandom_range(0, 255)));
    end else if (r == 2 && k == 0) begin
      m[9] = 8'($urandom_range(2, 255));
    end
    return m;
  endfunction

  // ---------------- ready generator ----------------
  initial begin
    add_ready = 1'b0;
    cancel_ready = 1'b0;
    exec_ready = 1'b0;
  end
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: begin
        add_ready = $urandom_range(0, 1) == 1;
        cancel_ready = $urandom_range(0, 1) == 1;
        exec_ready = $urandom_range(0, 1) == 1;
      end
      1: begin
        add_ready = 1'b0;
        cancel_ready = 1'b0;
        exec_ready = 1'b0;
      end
      default: begin
        add_ready = 1'b1;
        cancel_ready = 1'b1;
        exec_ready = 1'b1;
      end
    endcase
  end

  // ---------------- monitor ----------------
  logic [W-1:0] last_cmd;
  bit stall_pending = 0;
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic hs;
    int nv;
    if (!rst_n) begin
      stall_pending = 0;
    end else if (add_valid || cancel_valid || exec_valid) begin
      nv = int'(add_valid) + int'(cancel_valid) + int'(exec_valid);
      check("one_valid", W'(nv), W'(1));
      if (add_valid) begin
        act = pack(2'd1, add_order_id, add_side, add_price, add_quantity);
        hs = add_ready;
      end else if (cancel_valid) begin
        act = pack(2'd2, cancel_order_id, 1'b0, 32'd0, 32'd0);
        hs = cancel_ready;
      end else begin
        act = pack(2'd3, exec_order_id, 1'b0, 32'd0, exec_quantity);
        hs = exec_ready;
      end
      if (stall_pending) check("cmd_hold", act, last_cmd);
      if (hs) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_cmd: got %0h, required no command", act);
        end else begin
          check("cmd", act, exp_q.pop_front());
        end
        stall_pending = 0;
      end else begin
        stall_pending = 1;
        last_cmd = act;
      end
    end else begin
      stall_pending = 0;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    bq_t m;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    s_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_valids", {add_valid, cancel_valid, exec_valid}, 0);
    check("rst_msg_count", msg_count, 0);
    check("rst_err_count", err_count, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    #1;
    check("s_ready_before_clk", s_ready, 0);
    @(posedge clk);
    #1;
    check("s_ready_after_clk", s_ready, 1);

    // Add id=1 buy 10000/100, ready always high
    ready_mode = 2;
    send_msg(mk_add(64'd1, 8'h00, 32'd10000, 32'd100));
    check("add_latency", add_valid, 1);
    check("add_price", add_price, 32'd10000);
    drain();

    // Cancel id=4 with ready held low for 5 valid cycles
    ready_mode = 1;
    send_msg(mk_cancel(64'd4));
    cnt = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (cancel_valid) begin
        cnt++;
        check("stall_s_ready", s_ready, 0);
        if (cnt == 5) ready_mode = 2;
      end else if (cnt > 0) begin
        break;
      end
    end
    check("cancel_high_cycles", cnt, 6);
    drain();

    // Execute then Add back to back with random readies
    ready_mode = 0;
    send_msg(mk_exec(64'd1, 32'd30));
    send_msg(mk_add(64'd2, 8'h01, 32'd10100, 32'd50));
    drain();

    // Truncated Add (10 bytes), then Cancel 999
    m = mk_add(64'd3, 8'h00, 32'd5, 32'd6);
    while (m.size() > 10) void'(m.pop_back());
    send_msg(m);
    send_msg(mk_cancel(64'd999));
    drain();

    // Unknown type, then Add with side 0x02
    m = {};
    m.push_back(8'h5A);
    for (int i = 0; i < 4; i++) m.push_back(8'($urandom_range(0, 255)));
    send_msg(m);
    send_msg(mk_add(64'd7, 8'h02, 32'd1, 32'd1));
    drain();
    check("idle_after_errors", dbg_state, 0);

    // Reset while an add is pending
    ready_mode = 1;
    send_msg(mk_add(64'd11, 8'h01, 32'd22, 32'd33));
    cnt = 0;
    while (!add_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("add_pending", add_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_drop_valid", add_valid, 0);
    check("rst_counters", {msg_count, err_count}, 0);
    exp_q.delete();
    exp_msg = 16'd0;
    exp_err = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ready_mode = 2;
    send_msg(mk_exec(64'd12345, 32'd77));
    drain();

    // Random traffic
    ready_mode = 0;
    for (int i = 0; i < 60; i++) send_msg(mk_random());
    drain();
    check("final_state", dbg_state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
